decrypt: RTL and testbench

DECRYPT -- requirements
Module: decrypt

---
 rtl/decrypt.sv | 135 +++++++++++++
 tb/tb_decrypt.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decrypt.sv
// LWE decryption engine: streams ciphertext elements with matching key elements and
// emits the decoded plaintext. Define DECRYPT_ROUNDING_EN for round-to-nearest decode.
module decrypt #(
   parameter int PLAINTEXT_MODULUS  = 64,
   parameter int PLAINTEXT_WIDTH    = 6,
   parameter int CIPHERTEXT_MODULUS = 1024,
   parameter int CIPHERTEXT_WIDTH   = 10,
   parameter int DIMENSION          = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        ct_valid,
   output logic                        ct_ready,
   input  logic [CIPHERTEXT_WIDTH-1:0] ct_element,
   input  logic [CIPHERTEXT_WIDTH-1:0] sk_element,
   output logic                        pt_valid,
   input  logic                        pt_ready,
   output logic [PLAINTEXT_WIDTH-1:0]  plaintext
);

   // state  | meaning
   // ACCUM  | accepting elements, ct_ready=1, pt_valid=0
   // OUTPUT | holding decoded plaintext, ct_ready=0, pt_valid=1

   localparam int CW = CIPHERTEXT_WIDTH;
   localparam int PW = PLAINTEXT_WIDTH;
   localparam int IW = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(DIMENSION);

`ifdef DECRYPT_ROUNDING_EN
   localparam logic [CW-1:0] OFFSET = CW'(1) << (CW - PW - 1);
`else
   localparam logic [CW-1:0] OFFSET = '0;
`endif

   generate
      if (PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH)) begin : g_bad_t
         $error("PLAINTEXT_MODULUS must equal 2**PLAINTEXT_WIDTH");
      end
      if (CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH)) begin : g_bad_q
         $error("CIPHERTEXT_MODULUS must equal 2**CIPHERTEXT_WIDTH");
      end
      if (CIPHERTEXT_WIDTH <= PLAINTEXT_WIDTH) begin : g_bad_w
         $error("CIPHERTEXT_WIDTH must exceed PLAINTEXT_WIDTH");
      end
   endgenerate

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   acc_q, acc_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   plaintext_q, plaintext_d;
   logic            pt_valid_q, pt_valid_d;
   logic            ct_ready_q, ct_ready_d;

   logic [CW-1:0]   product;
   logic [CW-1:0]   residual;
   logic [CW-1:0]   rounded;
   logic            xfer;

   assign product  = ct_element * sk_element;
   assign residual = acc_q + ct_element;
   assign rounded  = residual + OFFSET;
   assign xfer     = ct_valid && ct_ready_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      plaintext_d = plaintext_q;
      pt_valid_d  = pt_valid_q;
      ct_ready_d  = ct_ready_q;
      case (state_q)
         ACCUM: begin
            if (flush) begin
               // flush takes priority over an element offered in the same cycle
               acc_d = '0;
               idx_d = '0;
            end else if (xfer) begin
               if (idx_q == IDX_LAST) begin
                  plaintext_d = rounded[CW-1 -: PW];
                  acc_d       = '0;
                  idx_d       = '0;
                  state_d     = OUTPUT;
                  pt_valid_d  = 1'b1;
                  ct_ready_d  = 1'b0;
               end else begin
                  acc_d = acc_q - product;
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         OUTPUT: begin
            if (pt_ready) begin
               state_d    = ACCUM;
               pt_valid_d = 1'b0;
               ct_ready_d = 1'b1;
            end
         end
         default: begin
            state_d    = ACCUM;
            pt_valid_d = 1'b0;
            ct_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         idx_q       <= '0;
         plaintext_q <= '0;
         pt_valid_q  <= 1'b0;
         ct_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         plaintext_q <= plaintext_d;
         pt_valid_q  <= pt_valid_d;
         ct_ready_q  <= ct_ready_d;
      end
   end

   assign ct_ready  = ct_ready_q;
   assign pt_valid  = pt_valid_q;
   assign plaintext = plaintext_q;

endmodule

// File: tb/tb_decrypt.sv
// Directed bench for decrypt at default parameters; expectations follow DECRYPT_ROUNDING_EN.
`timescale 1ns/1ps
module tb_decrypt;

`ifdef DECRYPT_ROUNDING_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       flush = 1'b0;
   logic       ct_valid = 1'b0;
   logic       pt_ready = 1'b0;
   logic [9:0] ct_element = '0;
   logic [9:0] sk_element = '0;
   logic       ct_ready;
   logic       pt_valid;
   logic [5:0] plaintext;

   int total = 0;
   int bad   = 0;

   decrypt dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .ct_element (ct_element),
      .sk_element (sk_element),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .plaintext  (plaintext)
   );

   always #5 clk = ~clk;

   // Offer one element; waits (bounded) for ct_ready, returns with inputs idle at posedge+1.
   task automatic send(input logic [9:0] e, input logic [9:0] s, output bit ok);
      int n = 0;
      while (!ct_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ok = ct_ready;
      ct_element = e;
      sk_element = s;
      ct_valid   = 1'b1;
      @(posedge clk); #1;
      ct_valid   = 1'b0;
   endtask

   task automatic consume();
      pt_ready = 1'b1;
      @(posedge clk); #1;
      pt_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (pt_valid !== 1'b0 || plaintext !== 6'd0) begin
         bad++; $display("FAIL reset_out: pt_valid=%b plaintext=%0d want 0/0", pt_valid, plaintext);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (ct_ready !== 1'b1 || pt_valid !== 1'b0) begin
         bad++; $display("FAIL reset_release: ct_ready=%b pt_valid=%b want 1/0", ct_ready, pt_valid);
      end
   endtask

   task automatic run_ct(input string name, input logic [9:0] a, input logic [9:0] s,
                         input logic [9:0] b, input logic [5:0] exp);
      bit ok0, ok1;
      send(a, s, ok0);
      total++;
      if (pt_valid !== 1'b0) begin
         bad++; $display("FAIL %s_early: pt_valid=%b want 0", name, pt_valid);
      end
      send(b, 10'd0, ok1);
      total++;
      if (!ok0 || !ok1 || pt_valid !== 1'b1 || plaintext !== exp) begin
         bad++;
         $display("FAIL %s: ready_ok=%b%b pt_valid=%b plaintext=%0d want 1/%0d",
                  name, ok0, ok1, pt_valid, plaintext, exp);
      end
   endtask

   task automatic test_basic();
      run_ct("basic", 10'd100, 10'd3, 10'd337, 6'd2);
      consume();
      total++;
      if (ct_ready !== 1'b1 || pt_valid !== 1'b0) begin
         bad++; $display("FAIL basic_consume: ct_ready=%b pt_valid=%b want 1/0", ct_ready, pt_valid);
      end
   endtask

   task automatic test_rounding();
      run_ct("round27", 10'd100, 10'd3, 10'd327, RND ? 6'd2 : 6'd1);
      consume();
   endtask

   task automatic test_wrap();
      run_ct("wrap1008", 10'd1000, 10'd5, 10'd888, 6'd63);
      consume();
      run_ct("wrap1020", 10'd0, 10'd0, 10'd1020, RND ? 6'd0 : 6'd63);
      consume();
   endtask

   task automatic test_backpressure();
      run_ct("bp_first", 10'd100, 10'd3, 10'd327, RND ? 6'd2 : 6'd1);
      ct_element = 10'd500;
      sk_element = 10'd7;
      ct_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (ct_ready !== 1'b0 || pt_valid !== 1'b1 || plaintext !== (RND ? 6'd2 : 6'd1)) begin
            bad++;
            $display("FAIL bp_hold%0d: ct_ready=%b pt_valid=%b plaintext=%0d", i, ct_ready, pt_valid, plaintext);
         end
      end
      ct_valid = 1'b0;
      consume();
      total++;
      if (ct_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release: ct_ready=%b want 1", ct_ready);
      end
      run_ct("bp_next", 10'd100, 10'd3, 10'd337, 6'd2);
      consume();
   endtask

   task automatic test_flush();
      ct_element = 10'd200;
      sk_element = 10'd9;
      ct_valid   = 1'b1;
      flush      = 1'b1;
      @(posedge clk); #1;
      ct_valid = 1'b0;
      flush    = 1'b0;
      run_ct("flush_same", 10'd100, 10'd3, 10'd337, 6'd2);
      consume();
      begin
         bit ok;
         send(10'd50, 10'd7, ok);
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      run_ct("flush_mid", 10'd100, 10'd3, 10'd337, 6'd2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (pt_valid !== 1'b1 || plaintext !== 6'd2) begin
         bad++; $display("FAIL flush_output: pt_valid=%b plaintext=%0d want 1/2", pt_valid, plaintext);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      bit ok;
      send(10'd100, 10'd3, ok);
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (pt_valid !== 1'b0 || plaintext !== 6'd0) begin
         bad++; $display("FAIL rst_mid: pt_valid=%b plaintext=%0d want 0/0", pt_valid, plaintext);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      run_ct("rst_mid_next", 10'd100, 10'd3, 10'd337, 6'd2);
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (pt_valid !== 1'b0 || plaintext !== 6'd0) begin
         bad++; $display("FAIL rst_pending: pt_valid=%b plaintext=%0d want 0/0", pt_valid, plaintext);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (ct_ready !== 1'b1 || pt_valid !== 1'b0) begin
         bad++; $display("FAIL rst_pending_release: ct_ready=%b pt_valid=%b want 1/0", ct_ready, pt_valid);
      end
      run_ct("rst_pending_next", 10'd1000, 10'd5, 10'd888, 6'd63);
      consume();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_wrap();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
